// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl_pkg
// Brief    : Y86-64 icode/ifun encodings, BHT reset value, condition decode
//            and 2-bit saturating counter helpers shared by branch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package branch_ctrl_pkg;

    // Instruction codes used by the branch controller
    localparam logic [3:0] c_icode_opq = 4'h6;
    localparam logic [3:0] c_icode_jxx = 4'h7;

    // Jump / cmov function codes
    localparam logic [3:0] c_ifun_jmp = 4'h0;
    localparam logic [3:0] c_ifun_jle = 4'h1;
    localparam logic [3:0] c_ifun_jl  = 4'h2;
    localparam logic [3:0] c_ifun_je  = 4'h3;
    localparam logic [3:0] c_ifun_jne = 4'h4;
    localparam logic [3:0] c_ifun_jge = 4'h5;
    localparam logic [3:0] c_ifun_jg  = 4'h6;

    // Every BHT entry starts weakly taken
    localparam logic [1:0] c_bht_init = 2'b10;

    // Condition evaluation; cc is {ZF,SF,OF}
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf, sf, of;
        zf = cc[2];
        sf = cc[1];
        of = cc[0];
        case (ifun)
            c_ifun_jmp: cond_eval = 1'b1;
            c_ifun_jle: cond_eval = (sf ^ of) | zf;
            c_ifun_jl:  cond_eval = sf ^ of;
            c_ifun_je:  cond_eval = zf;
            c_ifun_jne: cond_eval = ~zf;
            c_ifun_jge: cond_eval = ~(sf ^ of);
            c_ifun_jg:  cond_eval = ~(sf ^ of) & ~zf;
            default:    cond_eval = 1'b0;
        endcase
    endfunction

    // Step a 2-bit counter toward taken/not-taken, clamping at the ends
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            sat_update = (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end else begin
            sat_update = (cnt == 2'b00) ? cnt : cnt - 2'b01;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_ctrl_bht_2bit.sv
`default_nettype none
// ============================================================================
// Module   : bht_2bit
// Brief    : Array of 2^IDX_W two-bit saturating counters. One asynchronous
//            read port (fetch) and one saturating update port (execute).
//            A same-cycle read and update at one index returns the old value.
// Revision : 1.0 - initial release
// ============================================================================
module bht_2bit
    import branch_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam int c_entries = 2 ** IDX_W;

    logic [1:0] w_cnt [c_entries];

    generate
        for (genvar gi = 0; gi < c_entries; gi++) begin : g_entry
            logic [1:0] r_cnt;

            // Per-entry counter: reset to weakly taken, step on a matching update
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_cnt <= c_bht_init;
                end else if (upd_en_i && (upd_idx_i == IDX_W'(gi))) begin
                    r_cnt <= sat_update(r_cnt, upd_taken_i);
                end
            end

            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign rd_cnt_o = w_cnt[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Brief    : Y86-64 branch/condition controller. Holds the CC register,
//            resolves Jxx/cmovXX in Execute, predicts conditional jumps at
//            Fetch from a 2-bit BHT, issues a one-cycle registered flush plus
//            redirect on mispredict and keeps saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] f_pc_i,
    input  logic [3:0]        f_icode_i,
    input  logic [3:0]        f_ifun_i,
    output logic              f_pred_taken_o,
    input  logic              E_valid_i,
    input  logic [3:0]        E_icode_i,
    input  logic [3:0]        E_ifun_i,
    input  logic [ADDR_W-1:0] E_pc_i,
    input  logic              E_pred_taken_i,
    input  logic [ADDR_W-1:0] E_valC_i,
    input  logic [ADDR_W-1:0] E_valP_i,
    input  logic              e_alu_zf_i,
    input  logic              e_alu_sf_i,
    input  logic              e_alu_of_i,
    input  logic              e_set_cc_en_i,
    input  logic              e_stall_i,
    output logic [2:0]        cc_o,
    output logic              e_Cnd_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    logic [2:0]        r_cc;
    logic              r_flush;
    logic [ADDR_W-1:0] r_redirect;
    logic [CNT_W-1:0]  r_br_cnt;
    logic [CNT_W-1:0]  r_mispred_cnt;

    logic              w_live;
    logic              w_resolve;
    logic              w_mispred;
    logic [1:0]        w_f_cnt;
    logic              w_unused;

    // A stalled, bubbled or wrong-path (flush cycle) E op never changes state
    assign w_live    = E_valid_i & ~e_stall_i & ~r_flush;
    assign w_resolve = w_live & (E_icode_i == c_icode_jxx) & (E_ifun_i != c_ifun_jmp);
    assign w_mispred = w_resolve & (e_Cnd_o != E_pred_taken_i);

    // Condition uses the registered flags left by the prior OPq
    assign e_Cnd_o = cond_eval(E_ifun_i, r_cc);

    bht_2bit #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rd_idx_i    (f_pc_i[IDX_W-1:0]),
        .rd_cnt_o    (w_f_cnt),
        .upd_en_i    (w_resolve),
        .upd_idx_i   (E_pc_i[IDX_W-1:0]),
        .upd_taken_i (e_Cnd_o)
    );

    // Unconditional jumps are always predicted taken; only the counter MSB matters
    assign f_pred_taken_o = (f_icode_i == c_icode_jxx) &
                            ((f_ifun_i == c_ifun_jmp) | w_f_cnt[1]);

    // Condition-code register: written only by a live OPq the hazard unit permits
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cc <= 3'b100;
        end else if (w_live && (E_icode_i == c_icode_opq) && e_set_cc_en_i) begin
            r_cc <= {e_alu_zf_i, e_alu_sf_i, e_alu_of_i};
        end
    end

    // One-cycle flush pulse; redirect target is captured with it and then held
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_flush    <= 1'b0;
            r_redirect <= '0;
        end else begin
            r_flush <= w_mispred;
            if (w_mispred) begin
                r_redirect <= e_Cnd_o ? E_valC_i : E_valP_i;
            end
        end
    end

    // Statistics counters stick at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 1'b1;
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign cc_o          = r_cc;
    assign flush_o       = r_flush;
    assign redirect_pc_o = r_redirect;
    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

    // Upper PC bits do not participate in BHT indexing
    assign w_unused = ^{f_pc_i[ADDR_W-1:IDX_W], E_pc_i[ADDR_W-1:IDX_W]};

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl
// Brief    : Self-checking bench for branch_ctrl: condition-decode table plus
//            directed sequences for mispredict, masking, stall, BHT ordering
//            and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    localparam int ADDR_W = 64;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 32;

    localparam logic [3:0] c_opq = 4'h6;
    localparam logic [3:0] c_jxx = 4'h7;
    localparam logic [3:0] c_jmp = 4'h0;
    localparam logic [3:0] c_jle = 4'h1;
    localparam logic [3:0] c_jl  = 4'h2;
    localparam logic [3:0] c_je  = 4'h3;
    localparam logic [3:0] c_jne = 4'h4;
    localparam logic [3:0] c_jge = 4'h5;
    localparam logic [3:0] c_jg  = 4'h6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] f_pc;
    logic [3:0]        f_icode, f_ifun;
    logic              f_pred;
    logic              e_valid;
    logic [3:0]        e_icode, e_ifun;
    logic [ADDR_W-1:0] e_pc, e_valc, e_valp;
    logic              e_pred;
    logic              zf, sf, of, set_cc_en, stall;
    logic [2:0]        cc;
    logic              cnd, flush;
    logic [ADDR_W-1:0] redirect;
    logic [CNT_W-1:0]  br_cnt, mis_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       z, s, o;
        logic [3:0] ifun;
        logic       exp_cnd;
    } vec_t;

    vec_t tbl [14];

    branch_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .f_pc_i         (f_pc),
        .f_icode_i      (f_icode),
        .f_ifun_i       (f_ifun),
        .f_pred_taken_o (f_pred),
        .E_valid_i      (e_valid),
        .E_icode_i      (e_icode),
        .E_ifun_i       (e_ifun),
        .E_pc_i         (e_pc),
        .E_pred_taken_i (e_pred),
        .E_valC_i       (e_valc),
        .E_valP_i       (e_valp),
        .e_alu_zf_i     (zf),
        .e_alu_sf_i     (sf),
        .e_alu_of_i     (of),
        .e_set_cc_en_i  (set_cc_en),
        .e_stall_i      (stall),
        .cc_o           (cc),
        .e_Cnd_o        (cnd),
        .flush_o        (flush),
        .redirect_pc_o  (redirect),
        .br_cnt_o       (br_cnt),
        .mispred_cnt_o  (mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; e_pc = '0;
        e_pred = 1'b0; e_valc = '0; e_valp = '0;
        zf = 1'b0; sf = 1'b0; of = 1'b0; set_cc_en = 1'b0; stall = 1'b0;
    endtask

    task automatic e_op(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] pc, input logic pred,
                        input logic [63:0] valc, input logic [63:0] valp);
        e_valid = 1'b1; e_icode = icode; e_ifun = ifun; e_pc = pc;
        e_pred = pred; e_valc = valc; e_valp = valp; set_cc_en = 1'b0;
    endtask

    task automatic e_opq(input logic z, input logic s, input logic o, input logic en);
        e_valid = 1'b1; e_icode = c_opq; e_ifun = 4'h1;
        zf = z; sf = s; of = o; set_cc_en = en;
    endtask

    task automatic f_in(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] pc);
        f_icode = icode; f_ifun = ifun; f_pc = pc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, c_jl,  1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, c_jge, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, c_jle, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, c_je,  1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, c_jne, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, c_jg,  1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, c_jle, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, c_jl,  1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, c_jge, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, c_jg,  1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, c_jl,  1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, c_jmp, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 4'h7,  1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, c_jne, 1'b1};

        rst_n = 1'b0;
        idle();
        f_icode = 4'h0; f_ifun = 4'h0; f_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state and initial prediction
        check("rst_cc", cc, 3'b100);
        check("rst_flush", flush, 0);
        check("rst_redirect", redirect, 0);
        check("rst_br", br_cnt, 0);
        check("rst_mis", mis_cnt, 0);
        f_in(c_jxx, c_jne, 64'h123); check("rst_pred_jne", f_pred, 1);
        f_in(c_jxx, c_jle, 64'h7);   check("rst_pred_jle", f_pred, 1);
        f_in(c_opq, c_jle, 64'h7);   check("pred_non_jxx", f_pred, 0);
        f_in(c_jxx, c_jmp, 64'h9);   check("pred_jmp", f_pred, 1);

        // CC write, write-enable gating and bubble gating
        e_opq(1'b0, 1'b1, 1'b0, 1'b1); step(); check("cc_load", cc, 3'b010);
        e_opq(1'b1, 1'b0, 1'b0, 1'b0); step(); check("cc_en0", cc, 3'b010);
        e_opq(1'b1, 1'b0, 1'b0, 1'b1); e_valid = 1'b0; step(); check("cc_bubble", cc, 3'b010);
        idle();
        e_icode = c_jxx; e_ifun = c_jl;  #1; check("cnd_jl", cnd, 1);
        e_ifun = c_jge; #1; check("cnd_jge", cnd, 0);

        // Condition decode table
        for (int i = 0; i < 14; i++) begin
            e_opq(tbl[i].z, tbl[i].s, tbl[i].o, 1'b1);
            step();
            check("tbl_cc", cc, {tbl[i].z, tbl[i].s, tbl[i].o});
            idle();
            e_icode = c_jxx; e_ifun = tbl[i].ifun;
            #1;
            check("tbl_cnd", cnd, tbl[i].exp_cnd);
        end

        // Mispredicted JE at 0x40 (ZF=0, predicted taken)
        e_opq(1'b0, 1'b0, 1'b0, 1'b1); step(); idle();
        f_in(c_jxx, c_je, 64'h40);
        e_op(c_jxx, c_je, 64'h40, 1'b1, 64'h1000, 64'h49);
        step();
        check("mp_flush", flush, 1);
        check("mp_redirect", redirect, 64'h49);
        check("mp_mis", mis_cnt, 1);
        check("mp_br", br_cnt, 1);
        check("mp_pred_01", f_pred, 0);
        // Would-be mispredicting JNE in the flush cycle is masked
        e_op(c_jxx, c_jne, 64'h40, 1'b0, 64'h2000, 64'h45);
        step();
        check("mask_flush", flush, 0);
        check("mask_br", br_cnt, 1);
        check("mask_mis", mis_cnt, 1);
        check("mask_redirect", redirect, 64'h49);
        check("mask_bht", f_pred, 0);
        // Second not-taken JE, correctly predicted: counter 01 -> 00
        e_op(c_jxx, c_je, 64'h40, 1'b0, 64'h1000, 64'h49);
        step();
        check("nt2_flush", flush, 0);
        check("nt2_br", br_cnt, 2);
        check("nt2_mis", mis_cnt, 1);
        // Taken JNE at 0x80 aliases index 0: 00 -> 01, still not-taken
        e_op(c_jxx, c_jne, 64'h80, 1'b0, 64'h2000, 64'h89);
        step();
        check("tk_flush", flush, 1);
        check("tk_redirect", redirect, 64'h2000);
        check("tk_br", br_cnt, 3);
        check("tk_mis", mis_cnt, 2);
        check("tk_pred_idx0", f_pred, 0);
        // OPq in the flush cycle must not write CC
        e_opq(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("mask_cc", cc, 3'b000);
        check("mask_cc_flush", flush, 0);

        // Stalled OPq: no CC write until released
        e_opq(1'b1, 1'b0, 1'b0, 1'b1); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_cc", cc, 3'b000);
        end
        stall = 1'b0; step(); check("release_cc", cc, 3'b100);
        // Stalled mispredicting JE at 0x41
        idle();
        e_op(c_jxx, c_je, 64'h41, 1'b0, 64'h3000, 64'h4a); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_flush", flush, 0);
            check("stall_br", br_cnt, 3);
        end
        stall = 1'b0; step();
        check("rel_flush", flush, 1);
        check("rel_redirect", redirect, 64'h3000);
        check("rel_br", br_cnt, 4);
        check("rel_mis", mis_cnt, 3);
        idle(); step();
        check("rel_flush_1cyc", flush, 0);

        // Saturation at 11 on index 1, then two not-taken steps
        f_in(c_jxx, c_je, 64'h41);
        e_op(c_jxx, c_je, 64'h41, 1'b1, 64'h3000, 64'h4a); step();
        e_op(c_jxx, c_jne, 64'h41, 1'b0, 64'h3000, 64'h4a); step();
        check("sat_pred_10", f_pred, 1);
        step();
        check("sat_pred_01", f_pred, 0);
        check("sat_br", br_cnt, 7);
        check("sat_mis", mis_cnt, 3);

        // Same-index fetch read and execute update in one cycle
        idle();
        f_in(c_jxx, c_je, 64'h02);
        e_op(c_jxx, c_jne, 64'h42, 1'b0, 64'h5000, 64'h4b);
        #1;
        check("same_idx_old", f_pred, 1);
        step();
        check("same_idx_new", f_pred, 0);
        check("same_idx_br", br_cnt, 8);

        // Asynchronous reset while flush is high
        e_op(c_jxx, c_jne, 64'h43, 1'b1, 64'h6000, 64'h4c);
        step();
        check("pre_rst_flush", flush, 1);
        check("pre_rst_mis", mis_cnt, 4);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_flush", flush, 0);
        check("arst_br", br_cnt, 0);
        check("arst_mis", mis_cnt, 0);
        check("arst_cc", cc, 3'b100);
        check("arst_redirect", redirect, 0);
        f_in(c_jxx, c_je, 64'h02);
        check("arst_bht", f_pred, 1);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_flush", flush, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
